// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
// Shares one vga_adapter pixel-write port among four rectangle-draw
// requesters. Arbitration is round-robin, and each granted rectangle is
// drawn at one pixel per clock in raster order. Pixels that fall off the
// screen are suppressed, but each one still uses its cycle.
//
// Ports
//   clock        system clock
//   resetn       synchronous active-low reset
//   req[3:0]     request per requester
//   rect_x/y     packed start coordinates, requester i at [8i+7:8i]
//   rect_w/h     packed width/height, requester i at [8i+7:8i]
//   rect_colour  packed colour, requester i at [3i+2:3i]
//   gnt[3:0]     one-hot grant, held for the whole transaction
//   done[3:0]    one-cycle completion pulse to the granted requester
//   busy         high whenever the arbiter is not idle
//   x, y, colour, plot  pixel write to vga_adapter
module vga_draw_arbiter #(
  parameter int unsigned X_MAX = 160,
  parameter int unsigned Y_MAX = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [31:0] rect_x,
  input  logic [31:0] rect_y,
  input  logic [31:0] rect_w,
  input  logic [31:0] rect_h,
  input  logic [11:0] rect_colour,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CW    = 8;   // coordinate / size width
  localparam int unsigned COLW  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state, state_d;
  logic [3:0]      gnt_d, done_d;
  logic            busy_d;
  logic [CW-1:0]   x_d, y_d;
  logic [COLW-1:0] colour_d;
  logic            plot_d;

  logic [1:0]      ptr, ptr_d;     // round-robin scan start
  logic [1:0]      idx, idx_d;     // index of the granted requester
  logic [CW-1:0]   bx, by, bw, bh; // latched rectangle
  logic [CW-1:0]   bx_d, by_d, bw_d, bh_d;
  logic [COLW-1:0] bc, bc_d;
  logic [CW-1:0]   cx, cy, cx_d, cy_d; // offset of the pixel now on the bus

  // Per-requester views of the packed rectangle fields
  logic [CW-1:0]   fx [N_REQ];
  logic [CW-1:0]   fy [N_REQ];
  logic [CW-1:0]   fw [N_REQ];
  logic [CW-1:0]   fh [N_REQ];
  logic [COLW-1:0] fc [N_REQ];

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      fx[i] = rect_x[CW*i +: CW];
      fy[i] = rect_y[CW*i +: CW];
      fw[i] = rect_w[CW*i +: CW];
      fh[i] = rect_h[CW*i +: CW];
      fc[i] = rect_colour[COLW*i +: COLW];
    end
  end

  // Round-robin pick: first set req bit at or above ptr, wrapping 3->0
  logic       arb_found;
  logic [1:0] arb_idx;
  logic [1:0] cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand = ptr + 2'(k);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Raster step from the pixel now on the bus
  logic          last_col, last_row;
  logic [CW-1:0] nx, ny;

  always_comb begin
    last_col = (cx == bw - 8'd1);
    last_row = (cy == bh - 8'd1);
    nx       = last_col ? 8'd0 : cx + 8'd1;
    ny       = last_col ? cy + 8'd1 : cy;
  end

  // Next-state and registered-output logic
  logic          emit;
  logic [CW-1:0] px, py;
  logic [CW:0]   sum_x, sum_y;

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    done_d   = 4'd0;
    busy_d   = busy;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    ptr_d    = ptr;
    idx_d    = idx;
    bx_d     = bx;
    by_d     = by;
    bw_d     = bw;
    bh_d     = bh;
    bc_d     = bc;
    cx_d     = cx;
    cy_d     = cy;
    emit     = 1'b0;
    px       = 8'd0;
    py       = 8'd0;
    sum_x    = 9'd0;
    sum_y    = 9'd0;

    case (state)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_LOAD;
          gnt_d   = 4'd1 << arb_idx;
          idx_d   = arb_idx;
          bx_d    = fx[arb_idx];
          by_d    = fy[arb_idx];
          bw_d    = fw[arb_idx];
          bh_d    = fh[arb_idx];
          bc_d    = fc[arb_idx];
          cx_d    = 8'd0;
          cy_d    = 8'd0;
        end
      end
      S_LOAD: begin
        if (bw == 8'd0 || bh == 8'd0) begin
          state_d = S_DONE;
          done_d  = gnt;
        end else begin
          // First pixel goes onto the bus as DRAW begins
          state_d = S_DRAW;
          emit    = 1'b1;
        end
      end
      S_DRAW: begin
        if (last_col && last_row) begin
          state_d = S_DONE;
          done_d  = gnt;
        end else begin
          emit = 1'b1;
          px   = nx;
          py   = ny;
          cx_d = nx;
          cy_d = ny;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 4'd0;
        ptr_d   = idx + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // 9-bit sums so off-screen pixels are dropped instead of wrapping
    if (emit) begin
      sum_x    = {1'b0, bx} + {1'b0, px};
      sum_y    = {1'b0, by} + {1'b0, py};
      x_d      = sum_x[CW-1:0];
      y_d      = sum_y[CW-1:0];
      colour_d = bc;
      plot_d   = (sum_x < 9'(X_MAX)) && (sum_y < 9'(Y_MAX));
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= S_IDLE;
      gnt    <= 4'd0;
      done   <= 4'd0;
      busy   <= 1'b0;
      x      <= 8'd0;
      y      <= 8'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      ptr    <= 2'd0;
      idx    <= 2'd0;
      bx     <= 8'd0;
      by     <= 8'd0;
      bw     <= 8'd0;
      bh     <= 8'd0;
      bc     <= 3'd0;
      cx     <= 8'd0;
      cy     <= 8'd0;
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      done   <= done_d;
      busy   <= busy_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
      ptr    <= ptr_d;
      idx    <= idx_d;
      bx     <= bx_d;
      by     <= by_d;
      bw     <= bw_d;
      bh     <= bh_d;
      bc     <= bc_d;
      cx     <= cx_d;
      cy     <= cy_d;
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: reset, single draw, round-robin,
// clipping, zero-size, reset mid-draw and field change after grant.
module tb_vga_draw_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] rect_x, rect_y, rect_w, rect_h;
  logic [11:0] rect_colour;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [7:0]  x, y;
  logic [2:0]  colour;
  logic        plot;

  int passed = 0;
  int total  = 0;

  vga_draw_arbiter #(.X_MAX(160), .Y_MAX(120)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req         (req),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int i, input int rx, input int ry,
                          input int rw, input int rh, input int rc);
    rect_x[8*i +: 8]      = 8'(rx);
    rect_y[8*i +: 8]      = 8'(ry);
    rect_w[8*i +: 8]      = 8'(rw);
    rect_h[8*i +: 8]      = 8'(rh);
    rect_colour[3*i +: 3] = 3'(rc);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    int nplot;
    logic exp_plot;
    resetn = 1'b0;
    req = 4'd0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;

    // ---- reset state ----
    do_reset();
    chk("rst_gnt",    32'(gnt),    32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_plot",   32'(plot),   32'd0);
    chk("rst_x",      32'(x),      32'd0);
    chk("rst_y",      32'(y),      32'd0);
    chk("rst_colour", 32'(colour), 32'd0);

    // ---- single request 16x8 at (144,50) ----
    set_rect(0, 144, 50, 16, 8, 3);
    req = 4'b0001;
    step();
    chk("t1_gnt",  32'(gnt),  32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_load_plot", 32'(plot), 32'd0);
    step();
    for (int i = 0; i < 128; i++) begin
      chk("t1_plot",   32'(plot),   32'd1);
      chk("t1_x",      32'(x),      32'(144 + i % 16));
      chk("t1_y",      32'(y),      32'(50 + i / 16));
      chk("t1_colour", 32'(colour), 32'd3);
      step();
    end
    chk("t1_done",      32'(done), 32'h1);
    chk("t1_done_plot", 32'(plot), 32'd0);
    req = 4'd0;
    step();
    chk("t1_done_clr", 32'(done), 32'd0);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_gnt_clr",  32'(gnt),  32'd0);

    // ---- round robin, all 2x1, starting from pointer 0 ----
    do_reset();
    for (int i = 0; i < 4; i++) set_rect(i, 10 * i, i, 2, 1, i + 1);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      int e;
      e = t % 4;
      step();
      chk("rr_gnt", 32'(gnt), 32'(1 << e));
      step();
      chk("rr_onehot", 32'($countones(gnt) <= 1), 32'd1);
      chk("rr_x0",   32'(x),    32'(10 * e));
      chk("rr_plot", 32'(plot), 32'd1);
      step();
      chk("rr_x1",   32'(x),    32'(10 * e + 1));
      step();
      chk("rr_done", 32'(done), 32'(1 << e));
      if (t == 4) req = 4'd0;
      step();
      chk("rr_idle_gnt",  32'(gnt),  32'd0);
      chk("rr_idle_busy", 32'(busy), 32'd0);
    end

    // ---- clipping: requester 1, 10x4 at (155,118) ----
    set_rect(1, 155, 118, 10, 4, 5);
    req = 4'b0010;
    step();
    chk("clip_gnt", 32'(gnt), 32'h2);
    step();
    nplot = 0;
    for (int i = 0; i < 40; i++) begin
      exp_plot = ((155 + i % 10) < 160) && ((118 + i / 10) < 120);
      if (plot) nplot++;
      chk("clip_plot", 32'(plot), 32'(exp_plot));
      chk("clip_x",    32'(x),    32'((155 + i % 10) & 255));
      step();
    end
    chk("clip_count", 32'(nplot), 32'd10);
    chk("clip_done",  32'(done),  32'h2);
    req = 4'd0;
    step();

    // ---- zero size (req 2) with requester 3 queued ----
    set_rect(2, 5, 5, 0, 5, 2);
    set_rect(3, 100, 100, 1, 1, 7);
    req = 4'b1100;
    step();
    chk("zero_gnt",  32'(gnt),  32'h4);
    chk("zero_plot", 32'(plot), 32'd0);
    step();
    chk("zero_done",      32'(done), 32'h4);
    chk("zero_done_plot", 32'(plot), 32'd0);
    req = 4'b1000;
    step();
    chk("zero_idle_gnt", 32'(gnt), 32'd0);
    step();
    chk("next_gnt", 32'(gnt), 32'h8);
    step();
    chk("next_plot", 32'(plot), 32'd1);
    chk("next_x",    32'(x),    32'd100);
    step();
    chk("next_done", 32'(done), 32'h8);
    req = 4'd0;
    step();

    // ---- reset mid-draw on the 20th pixel of a 16x16 ----
    set_rect(0, 0, 0, 16, 16, 1);
    req = 4'b0001;
    step();
    chk("mr_gnt", 32'(gnt), 32'h1);
    step();
    for (int i = 0; i < 19; i++) step();
    chk("mr_px20_x", 32'(x), 32'd3);
    chk("mr_px20_y", 32'(y), 32'd1);
    set_rect(2, 20, 30, 4, 1, 6);
    req = 4'b1100;
    resetn = 1'b0;
    step();
    chk("mr_plot", 32'(plot), 32'd0);
    chk("mr_gnt0", 32'(gnt),  32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    step();
    chk("mr_regnt", 32'(gnt), 32'h4);

    // ---- colour change after grant is ignored ----
    rect_colour[8:6] = 3'd1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("fc_plot",   32'(plot),   32'd1);
      chk("fc_x",      32'(x),      32'(20 + i));
      chk("fc_colour", 32'(colour), 32'd6);
      step();
    end
    chk("fc_done", 32'(done), 32'h4);
    req = 4'b1000;
    step();
    step();
    chk("fc_next_gnt", 32'(gnt), 32'h8);
    step();
    step();
    chk("fc_next_done", 32'(done), 32'h8);
    req = 4'd0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
